// File: rtl/plic_lite.sv
// plic_lite: interrupt gateways, priority/threshold arbitration and claim/complete port.
// Define PLIC_EDGE_EN to let EDGE_MASK sources pend on rising edges of src_irq.

module plic_gw #(
   parameter bit EDGE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic claim,
   input  logic complete,
   output logic pending
);
   typedef enum logic [1:0] {IDLE, PEND, INSV} gw_state_t;
   gw_state_t state;
   logic      req;

`ifdef PLIC_EDGE_EN
   logic hist, rearm, rise;
   assign rise = irq & ~hist;
   // an edge caught while in service is replayed once the source is completed
   assign req  = EDGE ? (rise | rearm) : irq;
`else
   logic unused_edge;
   assign unused_edge = EDGE;
   assign req         = irq;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
`ifdef PLIC_EDGE_EN
         hist  <= 1'b0;
         rearm <= 1'b0;
`endif
      end else begin
`ifdef PLIC_EDGE_EN
         hist <= irq;
         if (state == INSV && EDGE && rise)
            rearm <= 1'b1;
         else if (state == IDLE)
            rearm <= 1'b0;
`endif
         case (state)
            IDLE:    if (req)      state <= PEND;
            PEND:    if (claim)    state <= INSV;
            INSV:    if (complete) state <= IDLE;
            default:               state <= IDLE;
         endcase
      end
   end

   assign pending = (state == PEND);
endmodule

module plic_lite #(
   parameter int                 NUM_SRC   = 8,
   parameter int                 PRIO_W    = 3,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic               reg_we,
   input  logic               reg_re,
   input  logic [2:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic               reg_ready,
   output logic               meip,
   output logic [NUM_SRC-1:0] irq_vec
);
   logic [NUM_SRC-1:0]             en, pend, elig;
   logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
   logic [PRIO_W-1:0]              thr;
   logic [4:0]                     win_id;
   logic [PRIO_W-1:0]              win_prio;
   logic [31:0]                    rd_mux;
   logic                           claim, complete;
   logic                           unused_ok;

   assign claim     = reg_re && (reg_addr == 3'd4);
   assign complete  = reg_we && (reg_addr == 3'd4);
   assign unused_ok = ^{reg_wdata, EDGE_MASK};

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      plic_gw #(.EDGE(EDGE_MASK[g])) u_gw (
         .clk      (clk),
         .rst      (rst),
         .irq      (src_irq[g]),
         .claim    (claim && (win_id == 5'(g + 1))),
         .complete (complete && (reg_wdata[4:0] == 5'(g + 1))),
         .pending  (pend[g])
      );
      assign elig[g] = pend[g] & en[g] & (prio[g] > thr);
   end

   // strict > keeps the lowest index on equal priority
   always_comb begin
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (elig[i] && (win_id == '0 || prio[i] > win_prio)) begin
            win_id   = 5'(i + 1);
            win_prio = prio[i];
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         3'd0:    rd_mux = 32'(pend);
         3'd1:    rd_mux = 32'(en);
         3'd2:    rd_mux = 32'(prio);
         3'd3:    rd_mux = 32'(thr);
         3'd4:    rd_mux = 32'(win_id);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en        <= '0;
         prio      <= '0;
         thr       <= '0;
         meip      <= 1'b0;
         irq_vec   <= '0;
         reg_ready <= 1'b0;
         reg_rdata <= '0;
      end else begin
         meip      <= |elig;
         irq_vec   <= elig;
         reg_ready <= reg_we | reg_re;
         reg_rdata <= reg_re ? rd_mux : '0;
         if (reg_we) begin
            case (reg_addr)
               3'd1:    en   <= reg_wdata[NUM_SRC-1:0];
               3'd2:    prio <= reg_wdata[NUM_SRC*PRIO_W-1:0];
               3'd3:    thr  <= reg_wdata[PRIO_W-1:0];
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_plic_lite.sv
// Scoreboarded bench for plic_lite: read results queued at issue, checked when reg_ready returns.
module tb_plic_lite;
   localparam int NS = 8;
`ifdef PLIC_EDGE_EN
   localparam logic [31:0] RP = 32'd1;
`else
   localparam logic [31:0] RP = 32'd0;
`endif

   logic          clk = 1'b0, rst = 1'b1;
   logic [NS-1:0] src_irq = '0;
   logic          reg_we = 1'b0, reg_re = 1'b0;
   logic [2:0]    reg_addr = '0;
   logic [31:0]   reg_wdata = '0;
   logic [31:0]   reg_rdata;
   logic          reg_ready, meip;
   logic [NS-1:0] irq_vec;

   int          total = 0, bad = 0;
   logic [31:0] exp_q[$];
   bit          was_rd, was_wr, was_rst;

   plic_lite #(.NUM_SRC(NS), .PRIO_W(3), .EDGE_MASK(8'h01)) dut (
      .clk(clk), .rst(rst), .src_irq(src_irq), .reg_we(reg_we), .reg_re(reg_re),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .reg_ready(reg_ready), .meip(meip), .irq_vec(irq_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e);
      reg_re = 1'b1; reg_addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      reg_re = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [NS-1:0] m);
      src_irq = src_irq | m;
      @(negedge clk);
      src_irq = src_irq & ~m;
   endtask

   always @(posedge clk) begin
      was_rd = reg_re; was_wr = reg_we; was_rst = rst;
      #1;
      if (was_rd) begin
         chk("rd_ready", reg_ready, 1);
         chk("sb_depth", 32'(exp_q.size()), 1);
         if (exp_q.size() > 0) chk("rd_data", reg_rdata, exp_q.pop_front());
      end else if (was_wr) begin
         chk("wr_ready", reg_ready, 1);
         chk("wr_rdata", reg_rdata, 0);
      end else if (!was_rst) begin
         chk("idle_ready", reg_ready, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      cyc(3);
      chk("rst_meip", meip, 0);
      chk("rst_vec", irq_vec, 0);
      chk("rst_ready", reg_ready, 0);
      chk("rst_rdata", reg_rdata, 0);
      rst = 1'b0;

      // single pulse, 2-cycle latency, claim drops meip one cycle later
      wr(2, 3); wr(1, 1);
      pulse(8'h01);
      chk("t1_meip_early", meip, 0);
      cyc(1);
      chk("t1_meip", meip, 1);
      chk("t1_vec", irq_vec, 8'h01);
      rd(4, 1);
      chk("t1_meip_claim", meip, 1);
      cyc(1);
      chk("t1_meip_after", meip, 0);
      wr(4, 1); rd(0, 0);

      // priority ordering
      wr(2, (2 << 6) | (6 << 15)); wr(1, 32'h24);
      pulse(8'h24); cyc(1);
      rd(0, 32'h24);
      rd(4, 6); rd(4, 3); rd(4, 0);
      wr(4, 6); wr(4, 3); rd(0, 0);

      // tie to lowest index, threshold masking
      wr(2, (4 << 3) | (4 << 9)); wr(1, 32'h0a);
      pulse(8'h0a); cyc(1);
      chk("t3_meip", meip, 1);
      chk("t3_vec", irq_vec, 8'h0a);
      rd(4, 2);
      wr(3, 4); cyc(1);
      chk("t3_thr_meip", meip, 0);
      chk("t3_thr_vec", irq_vec, 0);
      rd(4, 0); rd(0, 32'h08);
      wr(3, 0); rd(4, 4);
      wr(4, 4); wr(4, 2); rd(0, 0);

      // level re-pend after complete; bogus complete ignored
      wr(2, 3); wr(1, 1);
      src_irq[0] = 1'b1;
      cyc(2);
      chk("t4_meip", meip, 1);
      rd(4, 1); cyc(1);
      chk("t4_meip_claimed", meip, 0);
      wr(4, 1);
      chk("t4_meip_c0", meip, 0);
      cyc(1);
      chk("t4_meip_c1", meip, 0);
      cyc(1);
      chk("t4_meip_c2", meip, 1);
      src_irq[0] = 1'b0;
      wr(4, 7); rd(0, 1);
      rd(4, 1); wr(4, 1); rd(0, 0);

      // edges during service: one re-arm in edge builds, nothing for level
      pulse(8'h01); cyc(1);
      rd(4, 1);
      pulse(8'h01); cyc(1);
      pulse(8'h01); cyc(1);
      wr(4, 1); cyc(2);
      rd(0, RP); rd(4, RP); rd(4, 0);
      wr(4, RP);

      // reset clears in-service state
      wr(2, 5 << 12); wr(1, 32'h10);
      pulse(8'h10); cyc(1);
      rd(4, 5);
      rst = 1'b1; cyc(1);
      chk("t6_rst_meip", meip, 0);
      chk("t6_rst_ready", reg_ready, 0);
      rst = 1'b0;
      rd(0, 0); rd(1, 0); rd(4, 0);
      chk("t6_meip", meip, 0);
      wr(2, 5 << 12); wr(1, 32'h10);
      pulse(8'h10); cyc(1);
      rd(4, 5);

      cyc(2);
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
